uart_rx_conditioner: RTL and testbench
======================================

Name: uart_rx_conditioner

Overview:
Receive-line front end that sits directly upstream of the epRISC UART's iRX input; the UART samples its output at 16x oversample.
- Synchronises the raw asynchronous RX pin into the iSClk domain.
- Rejects single-sample glitches with a 3-sample majority filter.
- Classifies the line as idle, active or break, and keeps a saturating glitch count for diagnostics.
- oRX connects straight to the UART's iRX; status outputs go to the interrupt/status logic.

Parameters:
OVERSAMPLE, 16, iSClk cycles per bit time.
IDLE_BITS, 10, consecutive high bit times before the line is declared idle.
BREAK_BITS, 11, consecutive low bit times before the line is declared in break.

Ports:
iSClk  in  1  oversample clock.
iRst  in  1  asynchronous active-high reset.
iRX  in  1  raw RX pin, asynchronous to iSClk.
iEnable  in  1  1 = majority filter in path; 0 = bypass (synchronised pin only).
iClearCnt  in  1  synchronous clear of oGlitchCnt.
oRX  out  1  conditioned RX, registered; feeds the UART iRX.
oIdle  out  1  level; line in IDLE state.
oBreak  out  1  level; line in BREAK state.
oBreakEdge  out  1  one-cycle pulse on entry to BREAK.
oGlitch  out  1  one-cycle pulse per rejected glitch.
oGlitchCnt  out  8  saturating count of rejected glitches.

Behaviour:
- Reset (iRst asynchronous, active-high; clock iSClk): sync flops = 1, sample shift register s[2:0] = 3'b111, oRX = 1, state = ACTIVE, oIdle = 0, oBreak = 0, oBreakEdge = 0, oGlitch = 0, oGlitchCnt = 0, both run counters = 0.
- Reset asserted mid-operation (including mid-break) aborts everything immediately to these values.
- Synchroniser: 2 flops, iRX -> y1 -> y2.
- s shifts every cycle regardless of iEnable: s[0] <= y2, s[1] <= s[0], s[2] <= s[1].
- iEnable = 1 path:
  - oRX <= majority(s[2:0]).
  - Latency: pin stable from capture edge E0 -> oRX changes after edge E4.
  - A 1-cycle pin pulse never reaches oRX.
- iEnable = 0 path: oRX <= y2, so oRX changes after edge E2. oGlitch is forced to 0.
- Toggling iEnable takes effect at the next edge. s is already current, so no stale data appears.
- Glitch detect (iEnable = 1 only): oGlitch <= (s[1] != s[0]) && (s[1] != s[2]).
- oGlitchCnt, each cycle:
  - increments on oGlitch = 1;
  - saturates at 255;
  - iClearCnt forces 0 and wins over a simultaneous increment.
- Run counters track oRX, not the pin:
  - hiCnt counts consecutive cycles with oRX = 1; loCnt counts consecutive cycles with oRX = 0.
  - Each resets to 0 on the opposite level.
  - Each saturates at its threshold.
  - Width = clog2(BREAK_BITS*OVERSAMPLE + 1).
- Line FSM states: ACTIVE, IDLE, BREAK. Transitions are evaluated on registered values:
  - ACTIVE -> IDLE when hiCnt reaches IDLE_BITS*OVERSAMPLE - 1 while oRX = 1.
  - ACTIVE -> BREAK when loCnt reaches BREAK_BITS*OVERSAMPLE - 1 while oRX = 0.
  - IDLE -> ACTIVE on the first cycle with oRX = 0.
  - BREAK -> ACTIVE on the first cycle with oRX = 1. hiCnt restarts from that cycle, so IDLE needs a full IDLE_BITS afterwards.
  - Otherwise the FSM holds its state.
- Outputs: oIdle = (state == IDLE) and oBreak = (state == BREAK), both registered. oBreakEdge is 1 for exactly the cycle after the ACTIVE -> BREAK transition and is not re-asserted while BREAK holds.
- A normal 0x00 frame (9 low bit times) never reaches BREAK with BREAK_BITS = 11.

Decomposition:
- Shared include epRISC_UART_defs.vh:
  - line-state encodings LINE_ACTIVE = 0, LINE_IDLE = 1, LINE_BREAK = 2;
  - default OVERSAMPLE = 16, used by both this block and the UART.
- Sub-module: epRISC_sync2, a generic 2-flop synchroniser with parameterised reset value (1 here). It is reused by later I/O blocks.
- The majority filter, glitch counter and FSM stay in this module.

Test Plan:
- Reset, then iRX held 1 for 200 cycles -> oRX = 1 throughout; oIdle rises exactly 160 cycles after reset release (IDLE_BITS = 10, OVERSAMPLE = 16); oBreak = 0.
- iEnable = 1; iRX driven low for 1 cycle, 3 times, spaced 20 cycles apart -> oRX stays 1; oGlitch pulses 3 times; oGlitchCnt = 3.
- iEnable = 1; iRX 1 -> 0 step at edge E0 -> oRX = 0 after E4; repeat with iEnable = 0 -> oRX = 0 after E2; oGlitch stays 0 both times.
- iRX low for 176 cycles -> oBreak = 1 and a single oBreakEdge pulse; hold low 100 more cycles -> no further pulse; iRX high -> oBreak clears, then oIdle after 160 more cycles.
- Glitch count driven to 255, then 2 more glitches -> stays 255; iClearCnt pulsed in the same cycle as a glitch -> 0; iRst asserted during BREAK -> oRX = 1, oBreak = 0, oGlitchCnt = 0 immediately.

Source files
------------

// File: rtl/uart_rx_conditioner_pkg.sv
// Shared definitions for the UART receive-line conditioner: line states,
// default timing constants and the 3-sample majority helper.
package uart_rx_conditioner_pkg;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;
    localparam int unsigned DEFAULT_IDLE_BITS  = 10;
    localparam int unsigned DEFAULT_BREAK_BITS = 11;
    localparam int unsigned GLITCH_CNT_W       = 8;

    typedef enum logic [1:0] {
        LINE_ACTIVE = 2'd0,
        LINE_IDLE   = 2'd1,
        LINE_BREAK  = 2'd2
    } lineState_t;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_conditioner_sync2.sv
// Generic two-flop synchroniser with a parameterised reset value.
module epRISC_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic iSClk,
    input  logic iRst,
    input  logic iD,
    output logic oQ
);

    logic meta;

    always_ff @(posedge iSClk or posedge iRst) begin
        if (iRst) begin
            meta <= RESET_VAL;
            oQ   <= RESET_VAL;
        end else begin
            meta <= iD;
            oQ   <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_conditioner.sv
// RX pin front end: synchronise, majority-filter single-sample glitches,
// classify the line as active/idle/break and count rejected glitches.
module uart_rx_conditioner
    import uart_rx_conditioner_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int unsigned IDLE_BITS  = DEFAULT_IDLE_BITS,
    parameter int unsigned BREAK_BITS = DEFAULT_BREAK_BITS
) (
    input  logic       iSClk,
    input  logic       iRst,
    input  logic       iRX,
    input  logic       iEnable,
    input  logic       iClearCnt,
    output logic       oRX,
    output logic       oIdle,
    output logic       oBreak,
    output logic       oBreakEdge,
    output logic       oGlitch,
    output logic [7:0] oGlitchCnt
);

    localparam int unsigned RUN_W       = $clog2(BREAK_BITS * OVERSAMPLE + 1);
    localparam int unsigned IDLE_LIMIT  = IDLE_BITS * OVERSAMPLE - 1;
    localparam int unsigned BREAK_LIMIT = BREAK_BITS * OVERSAMPLE - 1;

    logic                    rxSync;
    logic [2:0]              s;
    lineState_t              state, stateNext;
    logic [RUN_W-1:0]        hiCnt, loCnt, hiCntNext, loCntNext;
    logic                    rxNext, glitchNext, breakEdgeNext;
    logic [GLITCH_CNT_W-1:0] glitchCntNext;

    epRISC_sync2 #(.RESET_VAL(1'b1)) uSync (
        .iSClk (iSClk),
        .iRst  (iRst),
        .iD    (iRX),
        .oQ    (rxSync)
    );

    // Next-state and next-output logic; run counters follow oRX, not the pin.
    always_comb begin
        rxNext        = iEnable ? majority3(s) : rxSync;
        glitchNext    = iEnable && (s[1] != s[0]) && (s[1] != s[2]);
        glitchCntNext = oGlitchCnt;
        hiCntNext     = '0;
        loCntNext     = '0;
        stateNext     = state;
        breakEdgeNext = 1'b0;

        if (iClearCnt)
            glitchCntNext = '0;
        else if (oGlitch && (oGlitchCnt != '1))
            glitchCntNext = oGlitchCnt + GLITCH_CNT_W'(1);

        if (oRX)
            hiCntNext = (hiCnt == RUN_W'(IDLE_LIMIT)) ? hiCnt : hiCnt + RUN_W'(1);
        else
            loCntNext = (loCnt == RUN_W'(BREAK_LIMIT)) ? loCnt : loCnt + RUN_W'(1);

        unique case (state)
            LINE_ACTIVE: begin
                if (oRX && (hiCnt == RUN_W'(IDLE_LIMIT)))
                    stateNext = LINE_IDLE;
                else if (!oRX && (loCnt == RUN_W'(BREAK_LIMIT)))
                    stateNext = LINE_BREAK;
            end
            LINE_IDLE:  if (!oRX) stateNext = LINE_ACTIVE;
            LINE_BREAK: if (oRX)  stateNext = LINE_ACTIVE;
            default:              stateNext = LINE_ACTIVE;
        endcase

        breakEdgeNext = (state == LINE_ACTIVE) && (stateNext == LINE_BREAK);
    end

    always_ff @(posedge iSClk or posedge iRst) begin
        if (iRst) begin
            s          <= 3'b111;
            oRX        <= 1'b1;
            state      <= LINE_ACTIVE;
            hiCnt      <= '0;
            loCnt      <= '0;
            oIdle      <= 1'b0;
            oBreak     <= 1'b0;
            oBreakEdge <= 1'b0;
            oGlitch    <= 1'b0;
            oGlitchCnt <= '0;
        end else begin
            s          <= {s[1:0], rxSync};
            oRX        <= rxNext;
            state      <= stateNext;
            hiCnt      <= hiCntNext;
            loCnt      <= loCntNext;
            oIdle      <= (stateNext == LINE_IDLE);
            oBreak     <= (stateNext == LINE_BREAK);
            oBreakEdge <= breakEdgeNext;
            oGlitch    <= glitchNext;
            oGlitchCnt <= glitchCntNext;
        end
    end

endmodule

// File: tb/tb_uart_rx_conditioner.sv
// Directed and randomized bench for uart_rx_conditioner against a
// cycle-level behavioural model built from pin history and run lengths.
module tb_uart_rx_conditioner;

    logic       iSClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iRX = 1'b1;
    logic       iEnable = 1'b1;
    logic       iClearCnt = 1'b0;
    logic       oRX, oIdle, oBreak, oBreakEdge, oGlitch;
    logic [7:0] oGlitchCnt;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Model state: pin samples newest-first, line state 0/1/2 = active/idle/break.
    logic [5:0] ph;
    int         mState, hiRun, loRun, mCnt;
    logic       mOrx, mGlitch, mBreakEdge;

    uart_rx_conditioner dut (
        .iSClk      (iSClk),
        .iRst       (iRst),
        .iRX        (iRX),
        .iEnable    (iEnable),
        .iClearCnt  (iClearCnt),
        .oRX        (oRX),
        .oIdle      (oIdle),
        .oBreak     (oBreak),
        .oBreakEdge (oBreakEdge),
        .oGlitch    (oGlitch),
        .oGlitchCnt (oGlitchCnt)
    );

    always #5 iSClk = ~iSClk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        ph = '1; mState = 0; hiRun = 0; loRun = 0; mCnt = 0;
        mOrx = 1'b1; mGlitch = 1'b0; mBreakEdge = 1'b0;
    endtask

    // One clock edge: advance the model with the sampled inputs, then compare.
    task automatic tick();
        logic pin, en, clr;
        int   newState;
        @(posedge iSClk);
        pin = iRX; en = iEnable; clr = iClearCnt;
        newState = mState;
        case (mState)
            0: if (mOrx && hiRun >= 159) newState = 1;
               else if (!mOrx && loRun >= 175) newState = 2;
            1: if (!mOrx) newState = 0;
            default: if (mOrx) newState = 0;
        endcase
        mBreakEdge = (mState == 0) && (newState == 2);
        hiRun = mOrx ? hiRun + 1 : 0;
        loRun = mOrx ? 0 : loRun + 1;
        if (clr) mCnt = 0;
        else if (mGlitch && mCnt < 255) mCnt++;
        ph = {ph[4:0], pin};
        mOrx = en ? ((int'(ph[3]) + int'(ph[4]) + int'(ph[5])) >= 2) : ph[2];
        mGlitch = en && (ph[4] != ph[3]) && (ph[4] != ph[5]);
        mState = newState;
        #1;
        check("oRX", 32'(oRX), 32'(mOrx));
        check("oIdle", 32'(oIdle), 32'(mState == 1));
        check("oBreak", 32'(oBreak), 32'(mState == 2));
        check("oBreakEdge", 32'(oBreakEdge), 32'(mBreakEdge));
        check("oGlitch", 32'(oGlitch), 32'(mGlitch));
        check("oGlitchCnt", 32'(oGlitchCnt), 32'(mCnt));
    endtask

    task automatic glitch3();
        iRX = 1'b0; tick();
        iRX = 1'b1; tick(); tick();
    endtask

    initial begin
        int idleAt, riseAt, clearAt, breakAt, first, gl, rxLow, edges;
        bit found;

        // Reset values
        #12;
        check("rst_oRX", 32'(oRX), 32'd1);
        check("rst_oIdle", 32'(oIdle), 32'd0);
        check("rst_oBreak", 32'(oBreak), 32'd0);
        check("rst_oGlitchCnt", 32'(oGlitchCnt), 32'd0);
        @(posedge iSClk); #1;
        iRst = 1'b0;
        modelReset();

        // Idle detection on a steady high line
        idleAt = -1; rxLow = 0; edges = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (oIdle === 1'b1 && idleAt < 0) idleAt = i;
            if (oRX !== 1'b1) rxLow++;
            if (oBreak !== 1'b0) edges++;
        end
        check("idleRise", 32'(idleAt), 32'd160);
        check("idleRxHigh", 32'(rxLow), 32'd0);
        check("idleNoBreak", 32'(edges), 32'd0);

        // Three single-cycle glitches
        gl = 0; rxLow = 0;
        for (int g = 0; g < 3; g++) begin
            iRX = 1'b0;
            for (int k = 0; k < 20; k++) begin
                tick();
                iRX = 1'b1;
                if (oGlitch === 1'b1) gl++;
                if (oRX !== 1'b1) rxLow++;
            end
        end
        check("glitchPulses", 32'(gl), 32'd3);
        check("glitchRxHigh", 32'(rxLow), 32'd0);
        check("glitchCnt3", 32'(oGlitchCnt), 32'd3);

        // Step latency, filtered then bypassed
        gl = 0;
        for (int pass = 0; pass < 2; pass++) begin
            iEnable = (pass == 0);
            iRX = 1'b0; first = -1;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (oRX === 1'b0 && first < 0) first = k;
                if (oGlitch === 1'b1) gl++;
            end
            check(pass == 0 ? "latencyFiltered" : "latencyBypass", 32'(first),
                  pass == 0 ? 32'd4 : 32'd2);
            iRX = 1'b1;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (oGlitch === 1'b1) gl++;
            end
        end
        iEnable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (oGlitch === 1'b1) gl++;
        end
        check("stepNoGlitch", 32'(gl), 32'd0);

        // Break entry, hold, exit and return to idle
        iRX = 1'b0; edges = 0; breakAt = -1;
        for (int k = 0; k < 276; k++) begin
            tick();
            if (oBreakEdge === 1'b1) edges++;
            if (oBreak === 1'b1 && breakAt < 0) breakAt = k;
        end
        check("breakAt", 32'(breakAt), 32'd180);
        check("breakEdgeOnce", 32'(edges), 32'd1);
        check("breakHeld", 32'(oBreak), 32'd1);
        iRX = 1'b1; riseAt = -1; clearAt = -1; idleAt = -1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (oRX === 1'b1 && riseAt < 0) riseAt = k;
            if (oBreak === 1'b0 && clearAt < 0) clearAt = k;
            if (oIdle === 1'b1 && idleAt < 0) idleAt = k;
        end
        check("breakRxRise", 32'(riseAt), 32'd4);
        check("breakClear", 32'(clearAt), 32'd5);
        check("idleAfterBreak", 32'(idleAt - riseAt), 32'd160);

        // Glitch counter saturation
        for (int g = 0; g < 252; g++) glitch3();
        repeat (6) tick();
        check("cntSat255", 32'(oGlitchCnt), 32'd255);
        glitch3(); glitch3();
        repeat (6) tick();
        check("cntStays255", 32'(oGlitchCnt), 32'd255);

        // Clear coinciding with a glitch increment
        for (int pass = 0; pass < 2; pass++) begin
            iRX = 1'b0; tick(); iRX = 1'b1;
            found = 1'b0;
            for (int k = 0; k < 8 && !found; k++) begin
                tick();
                if (oGlitch === 1'b1) found = 1'b1;
            end
            check("clearGlitchSeen", 32'(found), 32'd1);
            iClearCnt = 1'b1; tick(); iClearCnt = 1'b0;
            check("clearWins", 32'(oGlitchCnt), 32'd0);
            repeat (4) tick();
        end

        // Reset in the middle of a break
        glitch3(); glitch3();
        iRX = 1'b0;
        repeat (200) tick();
        check("preResetBreak", 32'(oBreak), 32'd1);
        check("preResetCnt", 32'(oGlitchCnt), 32'd2);
        #2 iRst = 1'b1;
        #1;
        check("midRst_oRX", 32'(oRX), 32'd1);
        check("midRst_oBreak", 32'(oBreak), 32'd0);
        check("midRst_oGlitchCnt", 32'(oGlitchCnt), 32'd0);
        check("midRst_oBreakEdge", 32'(oBreakEdge), 32'd0);
        iRX = 1'b1;
        @(posedge iSClk); #1;
        iRst = 1'b0;
        modelReset();

        // Randomized segments with enable toggles and sporadic clears
        for (int n = 0; n < 3000; ) begin
            int len;
            iRX = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(150, 200))
                                              : int'($urandom_range(1, 12));
            for (int k = 0; k < len; k++) begin
                iClearCnt = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 99) < 3) iEnable = ~iEnable;
                tick();
                n++;
            end
        end
        iClearCnt = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
